// File: rtl/hazard_ctrl.sv
`timescale 1ns/1ps
// hazard_ctrl: shadow scoreboard of the EX/MEM/WB slots of the 5-stage core.
// Drives operand forwarding, load-use/RAW stalls, redirect flushes and the memory-wait freeze.
module hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1,
    parameter int FWD_EN  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_rd_we_i,
    input  logic              id_is_load_i,
    input  logic              id_is_mem_i,
    input  logic              ex_pc_src_i,
    output logic              stall_if_o,
    output logic              stall_id_o,
    output logic              flush_id_o,
    output logic              flush_ex_o,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic              mem_busy_o
);

    localparam int               CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
    localparam logic [0:0]       ST_RUN   = 1'b0;
    localparam logic [0:0]       ST_WAIT  = 1'b1;

    logic              exValid_q, exWe_q, exIsLoad_q, exIsMem_q, exRs1Used_q, exRs2Used_q;
    logic [REG_AW-1:0] exRd_q, exRs1_q, exRs2_q;
    logic              memValid_q, memWe_q, memIsLoad_q, memIsMem_q;
    logic [REG_AW-1:0] memRd_q;
    logic              wbValid_q, wbWe_q;
    logic [REG_AW-1:0] wbRd_q;
    logic [CNT_W-1:0]  memCnt_q;
    logic [0:0]        state_q, state_d;

    logic exHit, memHit, wbHit, loadUse, rawAny, hazard;
    logic memBusy, freeze, advance, issue;
    logic stallIf, stallId, flushId, flushEx;
    logic [1:0] fwdA, fwdB;

    function automatic logic slotHit(input logic v, input logic we,
                                     input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] r);
        return v & we & (rd == r) & (r != '0);
    endfunction

    function automatic logic [1:0] fwdSel(input logic used, input logic [REG_AW-1:0] src,
                                          input logic exV, input logic mV, input logic mWe,
                                          input logic [REG_AW-1:0] mRd, input logic mLoad,
                                          input logic wV, input logic wWe,
                                          input logic [REG_AW-1:0] wRd);
        if (FWD_EN == 0 || !exV || !used) return 2'b00;
        // A load in MEM has no data yet; the load-use stall pushes it into WB first.
        if (slotHit(mV, mWe, mRd, src) && !mLoad) return 2'b01;
        if (slotHit(wV, wWe, wRd, src)) return 2'b10;
        return 2'b00;
    endfunction

    assign exHit   = (id_rs1_used_i & slotHit(exValid_q, exWe_q, exRd_q, id_rs1_i))
                   | (id_rs2_used_i & slotHit(exValid_q, exWe_q, exRd_q, id_rs2_i));
    assign memHit  = (id_rs1_used_i & slotHit(memValid_q, memWe_q, memRd_q, id_rs1_i))
                   | (id_rs2_used_i & slotHit(memValid_q, memWe_q, memRd_q, id_rs2_i));
    assign wbHit   = (id_rs1_used_i & slotHit(wbValid_q, wbWe_q, wbRd_q, id_rs1_i))
                   | (id_rs2_used_i & slotHit(wbValid_q, wbWe_q, wbRd_q, id_rs2_i));
    assign loadUse = id_valid_i & exIsLoad_q & exHit;
    assign rawAny  = id_valid_i & (exHit | memHit | wbHit);
    assign hazard  = (FWD_EN != 0) ? loadUse : rawAny;
    assign memBusy = memValid_q & memIsMem_q & (memCnt_q != CNT_LAST);

    always_comb begin
        state_d = state_q;
        freeze  = 1'b0;
        stallIf = 1'b0;
        stallId = 1'b0;
        flushId = 1'b0;
        flushEx = 1'b0;
        // The freeze starts on the cycle busy rises, before the state register catches up.
        case (state_q)
            ST_RUN: begin
                freeze = memBusy;
                if (memBusy) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                freeze = memBusy;
                if (!memBusy) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        if (freeze) begin
            stallIf = 1'b1;
            stallId = 1'b1;
        end else if (ex_pc_src_i) begin
            flushId = 1'b1;
            flushEx = 1'b1;
        end else if (hazard) begin
            stallIf = 1'b1;
            stallId = 1'b1;
            flushEx = 1'b1;
        end
    end

    assign advance = ~freeze;
    assign issue   = advance & ~ex_pc_src_i & ~hazard & id_valid_i;
    assign fwdA    = fwdSel(exRs1Used_q, exRs1_q, exValid_q, memValid_q, memWe_q, memRd_q,
                            memIsLoad_q, wbValid_q, wbWe_q, wbRd_q);
    assign fwdB    = fwdSel(exRs2Used_q, exRs2_q, exValid_q, memValid_q, memWe_q, memRd_q,
                            memIsLoad_q, wbValid_q, wbWe_q, wbRd_q);

    assign stall_if_o  = stallIf & ~rst;
    assign stall_id_o  = stallId & ~rst;
    assign flush_id_o  = flushId & ~rst;
    assign flush_ex_o  = flushEx & ~rst;
    assign mem_busy_o  = memBusy & ~rst;
    assign fwd_a_sel_o = rst ? 2'b00 : fwdA;
    assign fwd_b_sel_o = rst ? 2'b00 : fwdB;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            memCnt_q    <= '0;
            exValid_q   <= 1'b0;
            exWe_q      <= 1'b0;
            exIsLoad_q  <= 1'b0;
            exIsMem_q   <= 1'b0;
            exRs1Used_q <= 1'b0;
            exRs2Used_q <= 1'b0;
            exRd_q      <= '0;
            exRs1_q     <= '0;
            exRs2_q     <= '0;
            memValid_q  <= 1'b0;
            memWe_q     <= 1'b0;
            memIsLoad_q <= 1'b0;
            memIsMem_q  <= 1'b0;
            memRd_q     <= '0;
            wbValid_q   <= 1'b0;
            wbWe_q      <= 1'b0;
            wbRd_q      <= '0;
        end else begin
            state_q   <= state_d;
            memCnt_q  <= memBusy ? memCnt_q + 1'b1 : '0;
            wbValid_q <= advance & memValid_q;
            wbWe_q    <= memWe_q;
            wbRd_q    <= memRd_q;
            if (advance) begin
                memValid_q  <= exValid_q;
                memWe_q     <= exWe_q;
                memIsLoad_q <= exIsLoad_q;
                memIsMem_q  <= exIsMem_q;
                memRd_q     <= exRd_q;
                exValid_q   <= issue;
                exWe_q      <= id_rd_we_i;
                exIsLoad_q  <= id_is_load_i;
                exIsMem_q   <= id_is_mem_i;
                exRs1Used_q <= id_rs1_used_i;
                exRs2Used_q <= id_rs2_used_i;
                exRd_q      <= id_rd_i;
                exRs1_q     <= id_rs1_i;
                exRs2_q     <= id_rs2_i;
            end
        end
    end

endmodule
